// File: rtl/vga_txt_block_writer_pkg.sv
// Shared definitions for the VGA text block writer.
//   - Register-select codes of the VGA text controller register port.
//   - State encodings for the block sequencer and the single-transfer engine.
package vga_txt_pkg;

  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_DATA    = 8'h01;
  localparam logic [7:0] REG_CUR_AL  = 8'h02;
  localparam logic [7:0] REG_CUR_AH  = 8'h03;
  localparam logic [7:0] REG_CONTROL = 8'h04;

  // Block sequencer: which kind of transfer is in flight.
  typedef enum logic [1:0] {
    WrIdle,
    WrSet,   // cursor set transfer (SET_CS / SET_REL / SET_WAIT)
    WrDat,   // data transfer (DAT_CS / DAT_REL / DAT_WAIT)
    WrDone
  } wr_state_e;

  // Single-transfer handshake phases.
  typedef enum logic [1:0] {
    XfIdle,
    XfCs,
    XfRel,
    XfWait
  } xf_state_e;

endpackage

// File: rtl/vga_txt_block_writer_if.sv
// Command and register-port signals of the VGA text block writer.
//   master: the writer (takes commands, drives the controller register port)
//   slave : host/controller side
// Command: i_start_h, i_adr, i_len, i_char, i_mode_inc -> o_busy_h, o_done_h, o_err_h
// Register port: o_cmd, o_cursor_adr, o_port, o_cs_h, o_rl_wh <- i_ready_h
interface vga_txt_block_writer_if #(
  parameter int unsigned ADR_W = 11,
  parameter int unsigned LEN_W = 12
) ();

  logic             i_start_h;
  logic [ADR_W-1:0] i_adr;
  logic [LEN_W-1:0] i_len;
  logic [7:0]       i_char;
  logic             i_mode_inc;
  logic             o_busy_h;
  logic             o_done_h;
  logic             o_err_h;
  logic [7:0]       o_cmd;
  logic [ADR_W-1:0] o_cursor_adr;
  logic [7:0]       o_port;
  logic             o_cs_h;
  logic             o_rl_wh;
  logic             i_ready_h;

  modport master (
    input  i_start_h, i_adr, i_len, i_char, i_mode_inc, i_ready_h,
    output o_busy_h, o_done_h, o_err_h, o_cmd, o_cursor_adr, o_port, o_cs_h, o_rl_wh
  );

  modport slave (
    output i_start_h, i_adr, i_len, i_char, i_mode_inc, i_ready_h,
    input  o_busy_h, o_done_h, o_err_h, o_cmd, o_cursor_adr, o_port, o_cs_h, o_rl_wh
  );

endinterface

// File: rtl/vga_txt_block_writer_xfer.sv
// vga_reg_xfer: single-transfer handshake engine for the controller register port.
// A transfer is CS (one-cycle strobe) -> REL -> WAIT (until ready). ack pulses in the WAIT
// cycle that sees ready; a new req may be issued in that same cycle so back-to-back
// transfers start every 3 cycles.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req, req_cmd/data/adr     transfer request (accepted when idle or on ack)
//   ready                     controller ready, sampled in WAIT only
//   cs, ack                   strobe and completion pulse
//   tmo                       timeout pulse (VGA_WR_TIMEOUT_EN builds only)
//   bus_cmd/bus_data/bus_adr  register-port fields, held between transfers
// Config macro: VGA_WR_TIMEOUT_EN adds a TMO_W wait counter and the tmo output.
module vga_reg_xfer
  import vga_txt_pkg::*;
#(
  parameter int unsigned ADR_W = 11
`ifdef VGA_WR_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [7:0]       req_cmd,
  input  logic [7:0]       req_data,
  input  logic [ADR_W-1:0] req_adr,
  input  logic             ready,
  output logic             cs,
  output logic             ack,
`ifdef VGA_WR_TIMEOUT_EN
  output logic             tmo,
`endif
  output logic [7:0]       bus_cmd,
  output logic [7:0]       bus_data,
  output logic [ADR_W-1:0] bus_adr
);

  xf_state_e        state_q, state_d;
  logic [7:0]       cmd_q, data_q;
  logic [ADR_W-1:0] adr_q;
  logic             load;

`ifdef VGA_WR_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
`ifdef VGA_WR_TIMEOUT_EN
    tmo       = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      XfIdle: if (req) state_d = XfCs;
      XfCs: begin
        state_d = XfRel;
`ifdef VGA_WR_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      XfRel: state_d = XfWait;
      XfWait: begin
        if (ready) begin
          ack     = 1'b1;
          state_d = req ? XfCs : XfIdle;
`ifdef VGA_WR_TIMEOUT_EN
        end else if (tmo_cnt_q == '1) begin
          tmo     = 1'b1;
          state_d = XfIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
      end
      default: state_d = XfIdle;
    endcase
    load = req && ((state_q == XfIdle) || ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= XfIdle;
      cmd_q   <= '0;
      data_q  <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) cmd_q <= req_cmd;
      // Cursor and data fields each keep the value of their own last transfer.
      if (load && (req_cmd == REG_CUR_AH)) adr_q <= req_adr;
      if (load && (req_cmd != REG_CUR_AH)) data_q <= req_data;
    end
  end

`ifdef VGA_WR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign cs       = (state_q == XfCs);
  assign bus_cmd  = cmd_q;
  assign bus_data = data_q;
  assign bus_adr  = adr_q;

endmodule

// File: rtl/vga_txt_block_writer.sv
// vga_txt_block_writer: block writer for the VGA text controller register port.
// One command (start cell, length, char, mode) sets the cursor and streams LEN character
// writes, re-setting the cursor to cell 0 when the address reaches SCREEN_CELLS.
// Ports:
//   i_clk, i_rst_h   clock, async active-high reset
//   bus (master)     command inputs, busy/done/err status, register port (see interface)
// Config macro: VGA_WR_TIMEOUT_EN enables the ready timeout and the sticky o_err_h flag;
// without it o_err_h is tied 0 and the writer waits for ready indefinitely.
module vga_txt_block_writer
  import vga_txt_pkg::*;
#(
  parameter int unsigned ADR_W        = 11,
  parameter int unsigned LEN_W        = 12,
  parameter int unsigned SCREEN_CELLS = 2000,
  parameter int unsigned TMO_W        = 16
) (
  input logic                   i_clk,
  input logic                   i_rst_h,
  vga_txt_block_writer_if.master bus
);

  localparam logic [ADR_W:0] ScreenEnd = (ADR_W + 1)'(SCREEN_CELLS);

  wr_state_e        wr_q, wr_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             inc_q, inc_d;

  logic             req, ack;
  logic [7:0]       req_cmd, req_data;
  logic [ADR_W-1:0] req_adr;
  logic [ADR_W:0]   adr_inc;
  logic [7:0]       char_nxt;
  logic             wrap;

`ifdef VGA_WR_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo;
`endif

  assign adr_inc  = {1'b0, adr_q} + (ADR_W + 1)'(1);
  assign wrap     = (adr_inc == ScreenEnd);
  assign char_nxt = char_q + {7'd0, inc_q};

  // Sequencer: the step to the next cell is taken in the cycle the data transfer is
  // acknowledged, so the following transfer is requested without a dead cycle.
  always_comb begin
    wr_d     = wr_q;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    char_d   = char_q;
    inc_d    = inc_q;
    req      = 1'b0;
    req_cmd  = REG_DATA;
    req_data = char_q;
    req_adr  = adr_q;
`ifdef VGA_WR_TIMEOUT_EN
    err_d = err_q;
`endif
    unique case (wr_q)
      WrIdle: begin
        if (bus.i_start_h) begin
`ifdef VGA_WR_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (bus.i_len == '0) begin
            wr_d = WrDone;
          end else begin
            adr_d    = bus.i_adr;
            cnt_d    = bus.i_len;
            char_d   = bus.i_char;
            inc_d    = bus.i_mode_inc;
            req      = 1'b1;
            req_cmd  = REG_CUR_AH;
            req_adr  = bus.i_adr;
            req_data = bus.i_char;
            wr_d     = WrSet;
          end
        end
      end
      WrSet: begin
`ifdef VGA_WR_TIMEOUT_EN
        if (tmo) begin
          err_d = 1'b1;
          wr_d  = WrDone;
        end else
`endif
        if (ack) begin
          req  = 1'b1;
          wr_d = WrDat;
        end
      end
      WrDat: begin
`ifdef VGA_WR_TIMEOUT_EN
        if (tmo) begin
          err_d = 1'b1;
          wr_d  = WrDone;
        end else
`endif
        if (ack) begin
          cnt_d  = cnt_q - LEN_W'(1);
          char_d = char_nxt;
          adr_d  = wrap ? '0 : adr_inc[ADR_W-1:0];
          if (cnt_q == LEN_W'(1)) begin
            wr_d = WrDone;
          end else if (wrap) begin
            req     = 1'b1;
            req_cmd = REG_CUR_AH;
            req_adr = '0;
            wr_d    = WrSet;
          end else begin
            req      = 1'b1;
            req_data = char_nxt;
            req_adr  = adr_inc[ADR_W-1:0];
          end
        end
      end
      WrDone:  wr_d = WrIdle;
      default: wr_d = WrIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst_h) begin
    if (i_rst_h) begin
      wr_q   <= WrIdle;
      adr_q  <= '0;
      cnt_q  <= '0;
      char_q <= '0;
      inc_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      adr_q  <= adr_d;
      cnt_q  <= cnt_d;
      char_q <= char_d;
      inc_q  <= inc_d;
    end
  end

`ifdef VGA_WR_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst_h) begin
    if (i_rst_h) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign bus.o_err_h = err_q;
`else
  assign bus.o_err_h = 1'b0;
`endif

  vga_reg_xfer #(
    .ADR_W(ADR_W)
`ifdef VGA_WR_TIMEOUT_EN
    ,
    .TMO_W(TMO_W)
`endif
  ) u_xfer (
    .clk      (i_clk),
    .rst      (i_rst_h),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .req_adr  (req_adr),
    .ready    (bus.i_ready_h),
    .cs       (bus.o_cs_h),
    .ack      (ack),
`ifdef VGA_WR_TIMEOUT_EN
    .tmo      (tmo),
`endif
    .bus_cmd  (bus.o_cmd),
    .bus_data (bus.o_port),
    .bus_adr  (bus.o_cursor_adr)
  );

  assign bus.o_busy_h = (wr_q == WrSet) || (wr_q == WrDat);
  assign bus.o_done_h = (wr_q == WrDone);
  // Every transfer of this block is a write.
  assign bus.o_rl_wh  = bus.o_cs_h;

endmodule

// File: tb/tb_vga_txt_block_writer.sv
// Self-checking bench for vga_txt_block_writer. Expected register-port transfers are queued
// when a command is issued and popped by a monitor on each o_cs_h strobe.
module tb_vga_txt_block_writer;
  import vga_txt_pkg::*;

  localparam int unsigned ADR_W = 11;
  localparam int unsigned LEN_W = 12;
`ifdef VGA_WR_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
`else
  localparam int unsigned TMO_W = 16;
`endif

  typedef struct {
    logic [7:0]       cmd;
    logic [ADR_W-1:0] adr;
    logic [7:0]       data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  xfer_t exp_q[$];
  int   cs_cyc[$];
  int   cs_count = 0;
  int   done_count = 0;
  logic prev_cs = 1'b0;
  bit   sb_en = 1'b1;
  int   ready_delay = 0;
  bit   ready_stuck = 1'b0;
  int   rdy_cnt = 0;

  vga_txt_block_writer_if #(.ADR_W(ADR_W), .LEN_W(LEN_W)) bus ();

  vga_txt_block_writer #(
    .ADR_W       (ADR_W),
    .LEN_W       (LEN_W),
    .SCREEN_CELLS(2000),
    .TMO_W       (TMO_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_h(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor.
  always @(negedge clk) begin
    xfer_t e;
    if (bus.o_done_h === 1'b1) done_count++;
    if (bus.o_cs_h === 1'b1) begin
      cs_count++;
      cs_cyc.push_back(cyc);
      checks++;
      if (prev_cs === 1'b1) begin
        errors++;
        $display("FAIL cs_single: cs high on consecutive cycles at cycle %0d", cyc);
      end
      checks++;
      if (bus.o_rl_wh !== 1'b1) begin
        errors++;
        $display("FAIL rl_wh: got %b required 1", bus.o_rl_wh);
      end
      if (sb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: cmd=%h adr=%0d port=%h, none expected",
                   bus.o_cmd, bus.o_cursor_adr, bus.o_port);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_cmd !== e.cmd ||
              ((e.cmd == REG_CUR_AH) ? (bus.o_cursor_adr !== e.adr) : (bus.o_port !== e.data)))
          begin
            errors++;
            $display("FAIL xfer: got cmd=%h adr=%0d port=%h required cmd=%h adr=%0d port=%h",
                     bus.o_cmd, bus.o_cursor_adr, bus.o_port, e.cmd, e.adr, e.data);
          end
        end
      end
    end
    prev_cs = bus.o_cs_h;
  end

  // Controller ready model: ready rises ready_delay cycles after each strobe.
  always @(negedge clk) begin
    if (ready_stuck) begin
      bus.i_ready_h = 1'b0;
    end else if (bus.o_cs_h === 1'b1) begin
      rdy_cnt       = ready_delay;
      bus.i_ready_h = (ready_delay == 0);
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      bus.i_ready_h = (rdy_cnt == 0);
    end else begin
      bus.i_ready_h = 1'b1;
    end
  end

  task automatic clear_counts();
    cs_count   = 0;
    done_count = 0;
    cs_cyc.delete();
  endtask

  // Called at a negedge; returns one negedge later with start released.
  task automatic start_cmd(input int adr, input int len, input logic [7:0] ch, input bit inc,
                           input bit push);
    int a;
    logic [7:0] c;
    bus.i_start_h  = 1'b1;
    bus.i_adr      = ADR_W'(adr);
    bus.i_len      = LEN_W'(len);
    bus.i_char     = ch;
    bus.i_mode_inc = inc;
    if (push && len != 0) begin
      a = adr;
      c = ch;
      exp_q.push_back('{cmd: REG_CUR_AH, adr: ADR_W'(a), data: 8'h00});
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{cmd: REG_DATA, adr: '0, data: c});
        a++;
        c = c + (inc ? 8'd1 : 8'd0);
        if (i < len - 1 && a == 2000) begin
          a = 0;
          exp_q.push_back('{cmd: REG_CUR_AH, adr: '0, data: 8'h00});
        end
      end
    end
    @(negedge clk);
    bus.i_start_h = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int ncyc);
    ncyc = 0;
    while (bus.o_done_h !== 1'b1 && ncyc < bound) begin
      @(negedge clk);
      ncyc++;
    end
    checks++;
    if (bus.o_done_h !== 1'b1) begin
      errors++;
      $display("FAIL done_wait: no done within %0d cycles", bound);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({bus.o_busy_h, bus.o_done_h, bus.o_err_h, bus.o_cs_h, bus.o_rl_wh} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags: busy/done/err/cs/rl=%b required 00000", tag,
               {bus.o_busy_h, bus.o_done_h, bus.o_err_h, bus.o_cs_h, bus.o_rl_wh});
    end
    checks++;
    if (bus.o_cmd !== 8'h00 || bus.o_port !== 8'h00 || bus.o_cursor_adr !== '0) begin
      errors++;
      $display("FAIL %s_bus: cmd=%h port=%h adr=%0d required all 0", tag, bus.o_cmd,
               bus.o_port, bus.o_cursor_adr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start_h = 1'b0; bus.i_adr = '0; bus.i_len = '0; bus.i_char = '0;
    bus.i_mode_inc = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int n;
    bit bad_gap;
    clear_counts();
    ready_delay = 0;
    start_cmd(16, 5, 8'h41, 1'b0, 1'b1);
    checks++;
    if (bus.o_busy_h !== 1'b1) begin
      errors++; $display("FAIL fill_busy: got %b required 1", bus.o_busy_h);
    end
    wait_done(100, n);
    checks++;
    if (bus.o_busy_h !== 1'b0) begin
      errors++; $display("FAIL fill_busy_at_done: got %b required 0", bus.o_busy_h);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done_h !== 1'b0 || done_count != 1) begin
      errors++; $display("FAIL fill_done_once: done=%b count=%0d required 0/1", bus.o_done_h,
                         done_count);
    end
    checks++;
    if (cs_count != 6) begin
      errors++; $display("FAIL fill_cs_count: got %0d required 6", cs_count);
    end
    bad_gap = 1'b0;
    for (int i = 1; i < cs_cyc.size(); i++) if (cs_cyc[i] - cs_cyc[i-1] != 3) bad_gap = 1'b1;
    checks++;
    if (bad_gap) begin
      errors++; $display("FAIL fill_cs_spacing: strobes not 3 cycles apart");
    end
    checks++;
    if (bus.o_cmd !== REG_DATA || bus.o_port !== 8'h41 || bus.o_cursor_adr !== 11'd16) begin
      errors++; $display("FAIL fill_hold: cmd=%h port=%h adr=%0d required 01/41/16", bus.o_cmd,
                         bus.o_port, bus.o_cursor_adr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL fill_queue: %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_inc();
    int n;
    clear_counts();
    start_cmd(0, 3, 8'hFE, 1'b1, 1'b1);
    wait_done(100, n);
    @(negedge clk);
    checks++;
    if (cs_count != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL inc_count: cs=%0d left=%0d required 4/0", cs_count, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int n;
    clear_counts();
    start_cmd(1998, 4, 8'h30, 1'b1, 1'b1);
    wait_done(100, n);
    @(negedge clk);
    checks++;
    if (cs_count != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_count: cs=%0d left=%0d required 6/0", cs_count, exp_q.size());
    end
    checks++;
    if (bus.o_cursor_adr !== '0) begin
      errors++; $display("FAIL wrap_cursor: got %0d required 0", bus.o_cursor_adr);
    end
  endtask

  task automatic test_len0();
    clear_counts();
    start_cmd(5, 0, 8'h20, 1'b0, 1'b1);
    checks++;
    if (bus.o_done_h !== 1'b1 || bus.o_busy_h !== 1'b0) begin
      errors++; $display("FAIL len0_done: done=%b busy=%b required 1/0", bus.o_done_h,
                         bus.o_busy_h);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done_h !== 1'b0 || bus.o_busy_h !== 1'b0) begin
      errors++; $display("FAIL len0_after: done=%b busy=%b required 0/0", bus.o_done_h,
                         bus.o_busy_h);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_count != 0) begin
      errors++; $display("FAIL len0_cs: got %0d required 0", cs_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_counts();
    ready_delay = 10;
    start_cmd(256, 3, 8'h61, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    start_cmd(512, 2, 8'h7A, 1'b0, 1'b0);
    wait_done(300, n);
    repeat (30) @(negedge clk);
    checks++;
    if (cs_count != 4 || done_count != 1) begin
      errors++; $display("FAIL b2b_count: cs=%0d done=%0d required 4/1", cs_count, done_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_queue: %0d left required 0", exp_q.size());
    end
    ready_delay = 0;
  endtask

  task automatic test_timeout();
    int n;
`ifdef VGA_WR_TIMEOUT_EN
    clear_counts();
    ready_stuck = 1'b1;
    exp_q.push_back('{cmd: REG_CUR_AH, adr: 11'd5, data: 8'h00});
    start_cmd(5, 3, 8'h11, 1'b0, 1'b0);
    wait_done(64, n);
    checks++;
    if (bus.o_err_h !== 1'b1) begin
      errors++; $display("FAIL tmo_err: got %b required 1", bus.o_err_h);
    end
    checks++;
    if (n < 15 || n > 20 || cs_count != 1) begin
      errors++; $display("FAIL tmo_timing: done after %0d cycles cs=%0d required 15..20/1", n,
                         cs_count);
    end
    ready_stuck = 1'b0;
    @(negedge clk);
    start_cmd(0, 1, 8'h20, 1'b0, 1'b1);
    checks++;
    if (bus.o_err_h !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: got %b required 0", bus.o_err_h);
    end
    wait_done(50, n);
    @(negedge clk);
`else
    n = 0;
    checks++;
    if (bus.o_err_h !== 1'b0) begin
      errors++; $display("FAIL err_tied: got %b required 0", bus.o_err_h);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_counts();
    sb_en = 1'b0;
    ready_delay = 10;
    start_cmd(80, 5, 8'h55, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    repeat (30) @(negedge clk);
    checks++;
    if (done_count != 0 || cs_count != 0) begin
      errors++; $display("FAIL rst_mid_quiet: done=%0d cs=%0d required 0/0", done_count,
                         cs_count);
    end
    sb_en = 1'b1;
    ready_delay = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_inc();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
